// File: rtl/page_table_walker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : PageStruct (package)
//  Description : Shared types and constants for the Sv39/Sv48 page-table
//                walker: PTE layout, address-geometry constants, walker states.
//  Revision    : 1.0 - initial release
// ============================================================================
package PageStruct;

    localparam int PAGE_OFFSET = 12;   // bytes per page = 2**PAGE_OFFSET
    localparam int VPN_SEG_W   = 9;    // VPN bits consumed per level
    localparam int PTE_BYTES   = 8;    // size of one PTE in memory
    localparam int PTE_PPN_W   = 44;   // PPN field width inside a PTE

    // RISC-V PTE, MSB first: reserved[63:54], ppn[53:10], rsw[9:8], flags[7:0]
    typedef struct packed {
        logic [9:0]           reserved;
        logic [PTE_PPN_W-1:0] ppn;
        logic [1:0]           rsw;
        logic                 d;
        logic                 a;
        logic                 g;
        logic                 u;
        logic                 x;
        logic                 w;
        logic                 r;
        logic                 v;
    } PTEPack;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } walk_state_e;

endpackage
`default_nettype wire

// File: rtl/page_table_walker_pte_check.sv
`default_nettype none
// ============================================================================
//  Module      : pte_check
//  Description : Combinational PTE decoder. Splits a raw 64-bit PTE into its
//                fields and classifies it as leaf and/or fault for the level
//                currently being walked.
//  Revision    : 1.0 - initial release
// ============================================================================
module pte_check
    import PageStruct::*;
#(
    parameter int LEVELS = 3
) (
    input  logic [63:0]               pte_raw,
    input  logic [$clog2(LEVELS)-1:0] level,
    output PTEPack                    pte,
    output logic                      is_leaf,
    output logic                      is_fault
);

    logic [PTE_PPN_W-1:0] w_sp_mask;
    logic                 w_misaligned;
    logic                 w_bad_perm;
    logic                 w_rsvd;

    // Decode the PTE and apply validity, permission and superpage-alignment rules
    always_comb begin
        pte          = PTEPack'(pte_raw);
        is_leaf      = pte.r | pte.x;
        // Low PPN bits that must be zero for a superpage mapped at this level
        w_sp_mask    = (PTE_PPN_W'(1) << (VPN_SEG_W * int'(level))) - PTE_PPN_W'(1);
        w_misaligned = is_leaf && (level != '0) && ((pte.ppn & w_sp_mask) != '0);
        w_bad_perm   = !pte.r && pte.w;
        w_rsvd       = (pte.reserved != '0);
        is_fault     = !pte.v || w_bad_perm || w_rsvd || w_misaligned
                       || (!is_leaf && (level == '0));
    end

endmodule
`default_nettype wire

// File: rtl/page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : page_table_walker
//  Description : Multi-level RISC-V page-table walker (Sv39 / Sv48). Issues one
//                PTE read per level, follows non-leaf pointers and returns the
//                final PTE, its level and a page-fault flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module page_table_walker
    import PageStruct::*;
#(
    parameter int LEVELS = 3,
    parameter int PPN_W  = 44,
    parameter int VPN_W  = 9 * LEVELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [VPN_W-1:0]          req_vpn,
    input  logic [PPN_W-1:0]          req_root_ppn,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [63:0]               mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [63:0]               mem_resp_data,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output PTEPack                    resp_pte,
    output logic [$clog2(LEVELS)-1:0] resp_level,
    output logic                      resp_fault
);

    localparam int c_LVL_W = $clog2(LEVELS);

    walk_state_e          r_state;
    walk_state_e          w_state_nxt;
    logic [VPN_W-1:0]     r_vpn;
    logic [PPN_W-1:0]     r_ppn;
    logic [c_LVL_W-1:0]   r_level;
    PTEPack               r_resp_pte;
    logic [c_LVL_W-1:0]   r_resp_level;
    logic                 r_resp_fault;

    PTEPack               w_pte;
    logic                 w_leaf;
    logic                 w_fault;
    logic [VPN_SEG_W-1:0] w_vpn_seg;
    logic                 w_accept;
    logic                 w_pte_take;

    pte_check #(
        .LEVELS   (LEVELS)
    ) u_pte_check (
        .pte_raw  (mem_resp_data),
        .level    (r_level),
        .pte      (w_pte),
        .is_leaf  (w_leaf),
        .is_fault (w_fault)
    );

    assign w_vpn_seg    = r_vpn[VPN_SEG_W * r_level +: VPN_SEG_W];
    assign mem_req_addr = (64'(r_ppn) << PAGE_OFFSET)
                        + (64'(w_vpn_seg) << $clog2(PTE_BYTES));
    assign w_accept     = (r_state == ST_IDLE) && req_valid && !flush;
    assign w_pte_take   = (r_state == ST_WAIT) && mem_resp_valid && !flush;
    assign resp_pte     = r_resp_pte;
    assign resp_level   = r_resp_level;
    assign resp_fault   = r_resp_fault;

    // State register; reset forces IDLE immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs; flush masks every outgoing valid/ready
    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = !flush;
                if (w_accept) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = !flush;
                if (flush)              w_state_nxt = ST_IDLE;
                else if (mem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)               w_state_nxt = mem_resp_valid ? ST_IDLE : ST_DRAIN;
                else if (mem_resp_valid) w_state_nxt = (w_leaf || w_fault) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                resp_valid = !flush;
                if (flush || resp_ready) w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                // The read already issued must be swallowed before a new walk
                if (mem_resp_valid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Walk context and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpn        <= '0;
            r_ppn        <= '0;
            r_level      <= '0;
            r_resp_pte   <= '0;
            r_resp_level <= '0;
            r_resp_fault <= 1'b0;
        end else if (w_accept) begin
            r_vpn   <= req_vpn;
            r_ppn   <= req_root_ppn;
            r_level <= c_LVL_W'(LEVELS - 1);
        end else if (w_pte_take) begin
            if (!w_leaf && !w_fault) begin
                r_ppn   <= PPN_W'(w_pte.ppn);
                r_level <= r_level - c_LVL_W'(1);
            end else begin
                r_resp_pte   <= w_pte;
                r_resp_level <= r_level;
                r_resp_fault <= w_fault;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_table_walker
//  Description : Directed, table-driven bench for page_table_walker (Sv39) with
//                hand sequences for backpressure, flush, reset and one Sv48 walk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_page_table_walker;
    import PageStruct::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready;
    logic [26:0] req_vpn;
    logic [43:0] req_root_ppn;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        flush;
    logic        resp_valid, resp_ready;
    PTEPack      resp_pte;
    logic [1:0]  resp_level;
    logic        resp_fault;

    logic        req_valid4, req_ready4;
    logic [35:0] req_vpn4;
    logic        mem_req_valid4;
    logic        mem_req_ready4;
    logic [63:0] mem_req_addr4;
    logic        mem_resp_valid4;
    logic [63:0] mem_resp_data4;
    logic        resp_valid4;
    PTEPack      resp_pte4;
    logic [1:0]  resp_level4;
    logic        resp_fault4;

    page_table_walker #(.LEVELS(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_vpn(req_vpn), .req_root_ppn(req_root_ppn),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .flush(flush), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_pte(resp_pte), .resp_level(resp_level),
        .resp_fault(resp_fault)
    );

    page_table_walker #(.LEVELS(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_vpn(req_vpn4), .req_root_ppn(44'h80000),
        .mem_req_valid(mem_req_valid4), .mem_req_ready(mem_req_ready4),
        .mem_req_addr(mem_req_addr4), .mem_resp_valid(mem_resp_valid4),
        .mem_resp_data(mem_resp_data4), .flush(1'b0), .resp_valid(resp_valid4),
        .resp_ready(1'b1), .resp_pte(resp_pte4), .resp_level(resp_level4),
        .resp_fault(resp_fault4)
    );

    typedef struct packed {
        logic [26:0]      vpn;
        logic [43:0]      root;
        logic [2:0]       nreads;
        logic [3:0][63:0] addr;
        logic [3:0][63:0] data;
        logic [1:0]       exp_level;
        logic             exp_fault;
    } vec_t;

    int          n_vec = 0;
    int          n_bad = 0;
    int          resp_delay = 0;
    int          pend_cnt = 0;
    logic [63:0] pend_addr;
    logic [63:0] rd_log[$];
    logic [63:0] pmem [logic [63:0]];
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] nl(input logic [43:0] ppn);
        return {10'b0, ppn, 10'h001};
    endfunction

    function automatic logic [63:0] leaf(input logic [43:0] ppn, input logic [7:0] flags);
        return {10'b0, ppn, 2'b00, flags};
    endfunction

    function automatic logic [26:0] vpn3(input logic [8:0] s2, input logic [8:0] s1, input logic [8:0] s0);
        return {s2, s1, s0};
    endfunction

    function automatic vec_t mk(input logic [26:0] vpn, input logic [2:0] n,
                                input logic [63:0] a0, input logic [63:0] d0,
                                input logic [63:0] a1, input logic [63:0] d1,
                                input logic [63:0] a2, input logic [63:0] d2,
                                input logic [1:0] lvl, input logic flt);
        vec_t v;
        v.vpn = vpn; v.root = 44'h80000; v.nreads = n;
        v.addr = '0; v.data = '0;
        v.addr[0] = a0; v.data[0] = d0;
        v.addr[1] = a1; v.data[1] = d1;
        v.addr[2] = a2; v.data[2] = d2;
        v.exp_level = lvl; v.exp_fault = flt;
        return v;
    endfunction

    // Memory model: one response per accepted read, resp_delay cycles after WAIT entry
    initial begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = pmem.exists(pend_addr) ? pmem[pend_addr] : 64'h0;
                end
            end
            if (mem_req_valid && mem_req_ready && !rst) begin
                rd_log.push_back(mem_req_addr);
                pend_addr = mem_req_addr;
                pend_cnt  = 1 + resp_delay;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_mem(input vec_t v);
        pmem.delete();
        rd_log.delete();
        for (int i = 0; i < int'(v.nreads); i++) pmem[v.addr[i]] = v.data[i];
    endtask

    task automatic run_walk(input vec_t v, input int mem_stall, input int resp_stall, input string tag);
        int lat;
        int k;
        load_mem(v);
        mem_req_ready = (mem_stall == 0);
        req_vpn = v.vpn; req_root_ppn = v.root; req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        chk({tag, " accept"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        for (int s = 0; s < mem_stall; s++) begin
            chk({tag, " stall_valid"}, 64'(mem_req_valid), 64'd1);
            chk({tag, " stall_addr"}, mem_req_addr, v.addr[0]);
            @(negedge clk);
            lat++;
        end
        mem_req_ready = 1'b1;
        while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        if (mem_stall == 0) chk({tag, " latency"}, 64'(lat), 64'(2 * int'(v.nreads) + 1));
        for (int s = 0; s < resp_stall; s++) begin
            chk({tag, " hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, " hold_pte"}, resp_pte, v.data[v.nreads - 1]);
            chk({tag, " hold_level"}, 64'(resp_level), 64'(v.exp_level));
            @(negedge clk);
        end
        chk({tag, " level"}, 64'(resp_level), 64'(v.exp_level));
        chk({tag, " fault"}, 64'(resp_fault), 64'(v.exp_fault));
        chk({tag, " pte"}, resp_pte, v.data[v.nreads - 1]);
        chk({tag, " nreads"}, 64'(rd_log.size()), 64'(v.nreads));
        for (int i = 0; i < int'(v.nreads); i++)
            chk({tag, " addr"}, (i < rd_log.size()) ? rd_log[i] : '1, v.addr[i]);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, " back_idle"}, 64'(req_ready), 64'd1);
    endtask

    // Start a walk of vecs[idx] and stop at the negedge where the DUT sits in REQ
    task automatic start_to_req(input vec_t v);
        load_mem(v);
        req_vpn = v.vpn; req_root_ppn = v.root; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int cnt_rv, cnt_mv, k;
        rst = 1'b1; req_valid = 1'b0; req_vpn = '0; req_root_ppn = '0;
        mem_req_ready = 1'b1; flush = 1'b0; resp_ready = 1'b0;
        req_valid4 = 1'b0; req_vpn4 = '0; mem_req_ready4 = 1'b1;
        mem_resp_valid4 = 1'b0; mem_resp_data4 = '0;

        vecs[0] = mk(vpn3(1, 2, 3), 3, 64'h80000008, nl(44'h80001), 64'h80001010, nl(44'h80002),
                     64'h80002018, leaf(44'h12345, 8'h0F), 2'd0, 1'b0);
        vecs[1] = mk(vpn3(4, 0, 0), 1, 64'h80000020, leaf(44'h80000, 8'h0F), 0, 0, 0, 0, 2'd2, 1'b0);
        vecs[2] = mk(vpn3(5, 0, 0), 1, 64'h80000028, leaf(44'h80001, 8'h0F), 0, 0, 0, 0, 2'd2, 1'b1);
        vecs[3] = mk(vpn3(6, 7, 0), 2, 64'h80000030, nl(44'h80003), 64'h80003038, 64'h0, 0, 0, 2'd1, 1'b1);
        vecs[4] = mk(vpn3(9, 0, 0), 1, 64'h80000048, 64'h5, 0, 0, 0, 0, 2'd2, 1'b1);
        vecs[5] = mk(vpn3(10, 1, 2), 3, 64'h80000050, nl(44'h80004), 64'h80004008, nl(44'h80005),
                     64'h80005010, nl(44'h80006), 2'd0, 1'b1);
        vecs[6] = mk(vpn3(11, 0, 0), 1, 64'h80000058, 64'h8000000000000000 | leaf(44'h80000, 8'h0F),
                     0, 0, 0, 0, 2'd2, 1'b1);
        vecs[7] = mk(vpn3(12, 3, 0), 2, 64'h80000060, nl(44'h80007), 64'h80007018,
                     leaf(44'h80200, 8'h03), 0, 0, 2'd1, 1'b0);

        #12;
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_fault", 64'(resp_fault), 64'd0);
        chk("rst resp_level", 64'(resp_level), 64'd0);
        chk("rst resp_pte", resp_pte, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_walk(vecs[i], 0, 0, $sformatf("vec%0d", i));

        // Read request and result held under backpressure
        run_walk(vecs[0], 5, 3, "backpressure");

        // Flush while REQ: request withdrawn, back to IDLE
        mem_req_ready = 1'b0;
        start_to_req(vecs[0]);
        chk("flush_req pre_valid", 64'(mem_req_valid), 64'd1);
        flush = 1'b1;
        #1 chk("flush_req gated", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        mem_req_ready = 1'b1;
        #1 chk("flush_req idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("flush_req no_read", 64'(rd_log.size()), 64'd0);

        // Flush while DONE: result withdrawn
        start_to_req(vecs[1]);
        k = 0;
        while (!resp_valid && k < 20) begin @(negedge clk); k++; end
        chk("flush_done pre_valid", 64'(resp_valid), 64'd1);
        flush = 1'b1;
        #1 chk("flush_done gated", 64'(resp_valid), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_done idle", 64'(req_ready), 64'd1);

        // Flush and req_valid together in IDLE: nothing starts
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1 chk("flush_idle req_ready", 64'(req_ready), 64'd1);
        chk("flush_idle no_mem", 64'(mem_req_valid), 64'd0);

        // Flush in WAIT, response arrives late: drain it, stay silent
        @(negedge clk);
        resp_delay = 4;
        start_to_req(vecs[0]);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("drain busy", 64'(req_ready), 64'd0);
        cnt_rv = 0; cnt_mv = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (resp_valid) cnt_rv++;
            if (mem_req_valid) cnt_mv++;
        end
        chk("drain resp_valid", 64'(cnt_rv), 64'd0);
        chk("drain mem_req", 64'(cnt_mv), 64'd0);
        chk("drain idle", 64'(req_ready), 64'd1);
        resp_delay = 0;
        run_walk(vecs[0], 0, 0, "post_drain");

        // Flush in WAIT coincident with the response: straight to IDLE
        start_to_req(vecs[0]);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_coin idle", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("flush_coin resp", 64'(resp_valid), 64'd0);
        chk("flush_coin reads", 64'(rd_log.size()), 64'd1);

        // Asynchronous reset mid-WAIT; late response ignored
        resp_delay = 4;
        start_to_req(vecs[0]);
        @(negedge clk);
        chk("rst_wait in_wait", 64'(req_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait req_ready", 64'(req_ready), 64'd1);
        chk("rst_wait mem_req", 64'(mem_req_valid), 64'd0);
        chk("rst_wait resp_pte", resp_pte, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_rv = 0;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (resp_valid || mem_req_valid) cnt_rv++;
        end
        chk("rst_wait quiet", 64'(cnt_rv), 64'd0);
        resp_delay = 0;
        run_walk(vecs[3], 0, 0, "post_rst");

        // Sv48 four-level walk on the LEVELS=4 instance
        begin
            logic [3:0][63:0] a4;
            logic [3:0][63:0] d4;
            int lat4;
            a4[0] = 64'h80000008; d4[0] = nl(44'h80001);
            a4[1] = 64'h80001010; d4[1] = nl(44'h80002);
            a4[2] = 64'h80002018; d4[2] = nl(44'h80003);
            a4[3] = 64'h80003020; d4[3] = leaf(44'h12345, 8'h0F);
            req_vpn4 = {9'd1, 9'd2, 9'd3, 9'd4};
            req_valid4 = 1'b1;
            @(negedge clk);
            req_valid4 = 1'b0;
            lat4 = 1;
            for (int i = 0; i < 4; i++) begin
                k = 0;
                while (!mem_req_valid4 && k < 20) begin @(negedge clk); k++; lat4++; end
                chk("sv48 addr", mem_req_addr4, a4[i]);
                @(negedge clk);
                lat4++;
                mem_resp_valid4 = 1'b1; mem_resp_data4 = d4[i];
                @(negedge clk);
                lat4++;
                mem_resp_valid4 = 1'b0;
            end
            chk("sv48 resp_valid", 64'(resp_valid4), 64'd1);
            chk("sv48 latency", 64'(lat4), 64'd9);
            chk("sv48 level", 64'(resp_level4), 64'd0);
            chk("sv48 fault", 64'(resp_fault4), 64'd0);
            chk("sv48 pte", resp_pte4, d4[3]);
            chk("sv48 idle", 64'(req_ready4), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
